// File: rtl/uart_rx_fifo_mem.sv
// Storage for the UART receive FIFO: one synchronous write port, one asynchronous read port.
// Kept separate so it can be swapped for a distributed-RAM primitive.
module uart_rx_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Contents are intentionally not reset; the control logic never exposes stale entries.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: circular FIFO with a
// first-word-fall-through valid/ready output and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overrun,
    input  logic                  clear_overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overrun_q;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == COUNT_FULL);
    assign count     = count_q;
    assign overrun   = overrun_q;

    // A full FIFO that is popped this cycle still has room for the incoming byte.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    uart_rx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, DATA_WIDTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       clear_overrun;

    int passed;
    int total;

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .full          (full),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid      = 1'b0;
        in_data       = 8'h00;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        rst_n         = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({out_valid, count, full, overrun} !== {1'b0, 5'd0, 1'b0, 1'b0})
                $display("FAIL reset_idle cycle %0d: got valid=%b count=%0d full=%b ovr=%b, want 0/0/0/0",
                         i, out_valid, count, full, overrun);
            else passed++;
            step();
        end
    endtask

    task automatic test_single();
        // out_ready while empty: nothing happens
        out_ready = 1'b1;
        step();
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL empty_ready: got count=%0d valid=%b, want 0/0", count, out_valid);
        else passed++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h41 || count !== 5'd1)
            $display("FAIL single_push: got valid=%b data=%h count=%0d, want 1/41/1", out_valid, out_data, count);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || count !== 5'd0)
            $display("FAIL single_pop: got valid=%b count=%0d, want 0/0", out_valid, count);
        else passed++;
        // push into empty with out_ready high: no bypass, byte stays
        in_valid  = 1'b1;
        in_data   = 8'h42;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || count !== 5'd1 || out_data !== 8'h42)
            $display("FAIL no_bypass: got valid=%b count=%0d data=%h, want 1/1/42", out_valid, count, out_data);
        else passed++;
        step();
        out_ready = 1'b0;
        total++;
        if (count !== 5'd0)
            $display("FAIL no_bypass_drain: got count=%0d, want 0", count);
        else passed++;
    endtask

    task automatic test_fill_overflow();
        fill_ramp();
        total++;
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0)
            $display("FAIL fill: got full=%b count=%0d ovr=%b, want 1/16/0", full, count, overrun);
        else passed++;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        in_valid = 1'b0;
        total++;
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1)
            $display("FAIL overflow: got full=%b count=%0d ovr=%b, want 1/16/1", full, count, overrun);
        else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i))
                $display("FAIL overflow_drain[%0d]: got valid=%b data=%h, want 1/%h", i, out_valid, out_data, 8'(i));
            else passed++;
            step();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0)
            $display("FAIL overflow_empty: got valid=%b count=%0d full=%b, want 0/0/0", out_valid, count, full);
        else passed++;
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0)
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [$];
        fill_ramp();
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0)
            $display("FAIL full_push_pop: got count=%0d full=%b ovr=%b, want 16/1/0", count, full, overrun);
        else passed++;
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h55);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i])
                $display("FAIL full_pp_drain[%0d]: got valid=%b data=%h, want 1/%h", i, out_valid, out_data, exp_q[i]);
            else passed++;
            step();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL full_pp_empty: got valid=%b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        int max_count;
        max_count = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = 8'(i * 7 + 3);
            in_valid = 1'b1;
            in_data  = b;
            step();
            in_valid = 1'b0;
            if (int'(count) > max_count) max_count = int'(count);
            total++;
            if (out_valid !== 1'b1 || out_data !== b)
                $display("FAIL wrap[%0d]: got valid=%b data=%h, want 1/%h", i, out_valid, out_data, b);
            else passed++;
            step();
            if (int'(count) > max_count) max_count = int'(count);
            step();
        end
        out_ready = 1'b0;
        total++;
        if (max_count !== 1 || count !== 5'd0)
            $display("FAIL wrap_count: got max=%0d final=%0d, want 1/0", max_count, count);
        else passed++;
    endtask

    task automatic test_overrun_priority();
        fill_ramp();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        total++;
        if (overrun !== 1'b1)
            $display("FAIL ovr_set: got %b, want 1", overrun);
        else passed++;
        in_data       = 8'hEF;
        clear_overrun = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (overrun !== 1'b1 || count !== 5'd16 || out_data !== 8'h00)
            $display("FAIL ovr_set_wins: got ovr=%b count=%0d head=%h, want 1/16/00", overrun, count, out_data);
        else passed++;
        step();
        clear_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0)
            $display("FAIL ovr_clear_alone: got %b, want 0", overrun);
        else passed++;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (count !== 5'd5)
            $display("FAIL pre_reset_count: got %0d, want 5", count);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0 || full !== 1'b0 || overrun !== 1'b0)
            $display("FAIL async_reset: got count=%0d valid=%b full=%b ovr=%b, want 0/0/0/0",
                     count, out_valid, full, overrun);
        else passed++;
        step();
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL post_reset_empty: got count=%0d valid=%b, want 0/0", count, out_valid);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_overrun_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
